// File: rtl/i2c_result_rx.sv
// i2c_result_rx: receive-only I2C target for the fsmd result stream.
// Oversamples scl/sda on clk, decodes START/address/data/STOP, pulls sda low
// to ACK its own write address and every data byte, and presents each byte
// on rx_data with a one-cycle rx_valid strobe.
module i2c_result_rx #(
   parameter logic [6:0] DEV_ADDR    = 7'h50,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       addr_hit
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      DATA,
      DATA_ACK,
      IGNORE
   } state_t;

   // Synchroniser chains plus one delay flop per line for edge detection.
   // They reset to 1 so an idle bus does not look like an edge after reset.
   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic                   scl_dly_q, scl_dly_d;
   logic                   sda_dly_q, sda_dly_d;

   // Protocol state and registered outputs.
   state_t     state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       busy_q, busy_d;
   logic       addr_hit_q, addr_hit_d;
   logic       sda_oe_q, sda_oe_d;

   // Decoded bus events (all from synchronised copies).
   logic scl_s, sda_s;
   logic scl_rise, scl_fall;
   logic start_det, stop_det;

   // Shift the raw lines into the synchronisers and keep the previous sample.
   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_dly_d  = scl_sync_q[SYNC_STAGES-1];
      sda_dly_d  = sda_sync_q[SYNC_STAGES-1];
   end

   // Bus conditions: START/STOP need scl high on both samples so an sda
   // change that coincides with an scl edge is never mistaken for one.
   always_comb begin
      scl_s     = scl_sync_q[SYNC_STAGES-1];
      sda_s     = sda_sync_q[SYNC_STAGES-1];
      scl_rise  = scl_s & ~scl_dly_q;
      scl_fall  = ~scl_s & scl_dly_q;
      start_det = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
      stop_det  = scl_s & scl_dly_q & ~sda_dly_q & sda_s;
   end

   // Next-state logic: STOP beats START, which beats any bit activity.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      addr_hit_d = 1'b0;
      busy_d     = busy_q;
      sda_oe_d   = sda_oe_q;

      if (stop_det) begin
         state_d   = IDLE;
         bit_cnt_d = 4'd0;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
      end else if (start_det) begin
         state_d   = ADDR;
         bit_cnt_d = 4'd0;
         shift_d   = 8'h00;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end

            ADDR: begin
               if (scl_rise && (bit_cnt_q < 4'd8)) begin
                  shift_d   = {shift_q[6:0], sda_s};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
                  if ((shift_q[7:1] == DEV_ADDR) && !shift_q[0]) begin
                     state_d    = ADDR_ACK;
                     sda_oe_d   = 1'b1;
                     addr_hit_d = 1'b1;
                     busy_d     = 1'b1;
                  end else begin
                     state_d = IGNORE;
                  end
               end
            end

            ADDR_ACK, DATA_ACK: begin
               // Hold the ACK low across the ninth clock, release on its fall.
               if (scl_fall) begin
                  state_d   = DATA;
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = 4'd0;
               end
            end

            DATA: begin
               if (scl_rise && (bit_cnt_q < 4'd8)) begin
                  shift_d   = {shift_q[6:0], sda_s};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
                  state_d    = DATA_ACK;
                  rx_data_d  = shift_q;
                  rx_valid_d = 1'b1;
                  sda_oe_d   = 1'b1;
               end
            end

            IGNORE: begin
               state_d = IGNORE;
            end

            default: begin
               state_d  = IDLE;
               sda_oe_d = 1'b0;
               busy_d   = 1'b0;
            end
         endcase
      end
   end

   // Register everything; reset releases sda at once and parks the FSM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_sync_q <= {SYNC_STAGES{1'b1}};
         sda_sync_q <= {SYNC_STAGES{1'b1}};
         scl_dly_q  <= 1'b1;
         sda_dly_q  <= 1'b1;
         state_q    <= IDLE;
         bit_cnt_q  <= 4'd0;
         shift_q    <= 8'h00;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         addr_hit_q <= 1'b0;
         sda_oe_q   <= 1'b0;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_dly_q  <= scl_dly_d;
         sda_dly_q  <= sda_dly_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         busy_q     <= busy_d;
         addr_hit_q <= addr_hit_d;
         sda_oe_q   <= sda_oe_d;
      end
   end

   assign sda_oe   = sda_oe_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign busy     = busy_q;
   assign addr_hit = addr_hit_q;

endmodule

// File: tb/tb_i2c_result_rx.sv
// tb_i2c_result_rx: directed bench for i2c_result_rx acting as an I2C
// controller (scl half period = 8 clk) with an open-drain sda model.
module tb_i2c_result_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       sda_in;
   logic       sda_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       addr_hit;

   int n_cmp = 0;
   int n_err = 0;

   int   rv_cnt = 0;
   int   ah_cnt = 0;
   int   oe_cnt = 0;
   int   oe_bad = 0;
   logic oe_prev = 1'b0;

   // Wired-AND bus: the target pulling low wins over the controller.
   assign sda_in = m_sda & ~sda_oe;

   i2c_result_rx #(.DEV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .scl      (scl),
      .sda_in   (sda_in),
      .sda_oe   (sda_oe),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .busy     (busy),
      .addr_hit (addr_hit)
   );

   always #5 clk = ~clk;

   // Count strobes and watch for sda_oe rising while scl is high.
   always @(negedge clk) begin
      if (rx_valid) rv_cnt++;
      if (addr_hit) ah_cnt++;
      if (sda_oe) oe_cnt++;
      if (sda_oe && !oe_prev && scl) oe_bad++;
      oe_prev = sda_oe;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      scl = 1'b1;
      m_sda = 1'b1;
      wait_clk(3);
      rst = 1'b1;
      wait_clk(4);
   endtask

   task automatic send_bit(input logic b);
      wait_clk(3);
      m_sda = b;
      wait_clk(5);
      scl = 1'b1;
      wait_clk(8);
      scl = 1'b0;
   endtask

   task automatic send_bits(input logic [7:0] d, input int n);
      for (int i = 0; i < n; i++) send_bit(d[7-i]);
   endtask

   task automatic ack_bit(output logic ack);
      wait_clk(3);
      m_sda = 1'b1;
      wait_clk(5);
      scl = 1'b1;
      wait_clk(4);
      ack = (sda_in == 1'b0);
      wait_clk(4);
      scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      send_bits(d, 8);
      ack_bit(ack);
   endtask

   // Works from an idle bus or as a repeated START with scl low.
   task automatic do_start();
      if (scl == 1'b0) begin
         wait_clk(3);
         m_sda = 1'b1;
         wait_clk(5);
         scl = 1'b1;
      end
      wait_clk(8);
      m_sda = 1'b0;
      wait_clk(8);
      scl = 1'b0;
   endtask

   task automatic do_stop();
      wait_clk(3);
      m_sda = 1'b0;
      wait_clk(5);
      scl = 1'b1;
      wait_clk(8);
      m_sda = 1'b1;
      wait_clk(8);
   endtask

   task automatic test_reset();
      #1;
      n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("[TB] FAIL reset_sda_oe: got %b expected 0", sda_oe); end
      n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("[TB] FAIL reset_rx_data: got %h expected 00", rx_data); end
      n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (addr_hit !== 1'b0) begin n_err++; $display("[TB] FAIL reset_addr_hit: got %b expected 0", addr_hit); end
      wait_clk(3);
      rst = 1'b1;
      wait_clk(4);
   endtask

   task automatic test_wrong_addr();
      logic ack;
      int rv0, ah0, oe0;
      rv0 = rv_cnt; ah0 = ah_cnt; oe0 = oe_cnt;
      do_start();
      send_byte(8'hA2, ack);
      n_cmp++; if (ack !== 1'b0) begin n_err++; $display("[TB] FAIL wrong_addr_ack: got %b expected 0", ack); end
      send_byte(8'hFF, ack);
      n_cmp++; if (ack !== 1'b0) begin n_err++; $display("[TB] FAIL wrong_addr_data_ack: got %b expected 0", ack); end
      do_stop();
      n_cmp++; if (oe_cnt - oe0 !== 0) begin n_err++; $display("[TB] FAIL wrong_addr_oe_cycles: got %0d expected 0", oe_cnt - oe0); end
      n_cmp++; if (rv_cnt - rv0 !== 0) begin n_err++; $display("[TB] FAIL wrong_addr_rx_valid: got %0d expected 0", rv_cnt - rv0); end
      n_cmp++; if (ah_cnt - ah0 !== 0) begin n_err++; $display("[TB] FAIL wrong_addr_addr_hit: got %0d expected 0", ah_cnt - ah0); end
      n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("[TB] FAIL wrong_addr_rx_data: got %h expected 00", rx_data); end
   endtask

   task automatic test_single_write();
      logic ack;
      int rv0, ah0;
      rv0 = rv_cnt; ah0 = ah_cnt;
      do_start();
      send_byte(8'hA0, ack);
      n_cmp++; if (ack !== 1'b1) begin n_err++; $display("[TB] FAIL single_addr_ack: got %b expected 1", ack); end
      n_cmp++; if (ah_cnt - ah0 !== 1) begin n_err++; $display("[TB] FAIL single_addr_hit: got %0d expected 1", ah_cnt - ah0); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL single_busy_after_addr: got %b expected 1", busy); end
      send_byte(8'h3C, ack);
      n_cmp++; if (ack !== 1'b1) begin n_err++; $display("[TB] FAIL single_data_ack: got %b expected 1", ack); end
      n_cmp++; if (rx_data !== 8'h3C) begin n_err++; $display("[TB] FAIL single_rx_data: got %h expected 3c", rx_data); end
      n_cmp++; if (rv_cnt - rv0 !== 1) begin n_err++; $display("[TB] FAIL single_rx_valid: got %0d expected 1", rv_cnt - rv0); end
      do_stop();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL single_busy_after_stop: got %b expected 0", busy); end
      n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("[TB] FAIL single_oe_after_stop: got %b expected 0", sda_oe); end
   endtask

   task automatic test_read_ignored();
      logic ack;
      int rv0, ah0;
      rv0 = rv_cnt; ah0 = ah_cnt;
      do_start();
      send_byte(8'hA1, ack);
      n_cmp++; if (ack !== 1'b0) begin n_err++; $display("[TB] FAIL read_addr_ack: got %b expected 0", ack); end
      send_byte(8'h5A, ack);
      n_cmp++; if (ack !== 1'b0) begin n_err++; $display("[TB] FAIL read_data_ack: got %b expected 0", ack); end
      n_cmp++; if (rv_cnt - rv0 !== 0) begin n_err++; $display("[TB] FAIL read_rx_valid: got %0d expected 0", rv_cnt - rv0); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL read_busy: got %b expected 0", busy); end
      do_start();
      send_byte(8'hA0, ack);
      n_cmp++; if (ack !== 1'b1) begin n_err++; $display("[TB] FAIL read_then_write_ack: got %b expected 1", ack); end
      n_cmp++; if (ah_cnt - ah0 !== 1) begin n_err++; $display("[TB] FAIL read_then_write_hit: got %0d expected 1", ah_cnt - ah0); end
      do_stop();
   endtask

   task automatic test_back_to_back();
      logic ack;
      logic [7:0] bytes [3];
      int rv0;
      bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56;
      rv0 = rv_cnt;
      do_start();
      send_byte(8'hA0, ack);
      n_cmp++; if (ack !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_addr_ack: got %b expected 1", ack); end
      for (int i = 0; i < 3; i++) begin
         send_byte(bytes[i], ack);
         n_cmp++; if (ack !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_data_ack[%0d]: got %b expected 1", i, ack); end
         n_cmp++; if (rx_data !== bytes[i]) begin n_err++; $display("[TB] FAIL b2b_rx_data[%0d]: got %h expected %h", i, rx_data, bytes[i]); end
      end
      do_stop();
      n_cmp++; if (rv_cnt - rv0 !== 3) begin n_err++; $display("[TB] FAIL b2b_rx_valid: got %0d expected 3", rv_cnt - rv0); end
      n_cmp++; if (rx_data !== 8'h56) begin n_err++; $display("[TB] FAIL b2b_final_data: got %h expected 56", rx_data); end
   endtask

   task automatic test_partial_byte();
      logic ack;
      int rv0, ah0;
      rv0 = rv_cnt; ah0 = ah_cnt;
      do_start();
      send_byte(8'hA0, ack);
      send_bits(8'hAB, 5);
      do_start();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL partial_busy_after_rstart: got %b expected 0", busy); end
      n_cmp++; if (rx_data !== 8'h56) begin n_err++; $display("[TB] FAIL partial_rx_data_held: got %h expected 56", rx_data); end
      send_byte(8'hA0, ack);
      n_cmp++; if (ack !== 1'b1) begin n_err++; $display("[TB] FAIL partial_readdr_ack: got %b expected 1", ack); end
      send_byte(8'h07, ack);
      do_stop();
      n_cmp++; if (ah_cnt - ah0 !== 2) begin n_err++; $display("[TB] FAIL partial_addr_hit: got %0d expected 2", ah_cnt - ah0); end
      n_cmp++; if (rv_cnt - rv0 !== 1) begin n_err++; $display("[TB] FAIL partial_rx_valid: got %0d expected 1", rv_cnt - rv0); end
      n_cmp++; if (rx_data !== 8'h07) begin n_err++; $display("[TB] FAIL partial_rx_data: got %h expected 07", rx_data); end
   endtask

   task automatic test_reset_mid_transfer();
      logic ack;
      int rv0;
      do_start();
      send_byte(8'hA0, ack);
      send_bits(8'h11, 8);
      wait_clk(5);
      n_cmp++; if (sda_oe !== 1'b1) begin n_err++; $display("[TB] FAIL midrst_oe_before: got %b expected 1", sda_oe); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL midrst_busy_before: got %b expected 1", busy); end
      rst = 1'b0;
      #1;
      n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_oe_after: got %b expected 0", sda_oe); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_busy_after: got %b expected 0", busy); end
      n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("[TB] FAIL midrst_rx_data: got %h expected 00", rx_data); end
      wait_clk(2);
      rst = 1'b1;
      rv0 = rv_cnt;
      wait_clk(1);
      scl = 1'b1;
      wait_clk(8);
      scl = 1'b0;
      send_byte(8'h55, ack);
      n_cmp++; if (ack !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_no_ack: got %b expected 0", ack); end
      n_cmp++; if (rv_cnt - rv0 !== 0) begin n_err++; $display("[TB] FAIL midrst_no_valid: got %0d expected 0", rv_cnt - rv0); end
      do_stop();
      do_start();
      send_byte(8'hA0, ack);
      send_byte(8'h9E, ack);
      n_cmp++; if (ack !== 1'b1) begin n_err++; $display("[TB] FAIL midrst_resume_ack: got %b expected 1", ack); end
      do_stop();
      n_cmp++; if (rx_data !== 8'h9E) begin n_err++; $display("[TB] FAIL midrst_resume_data: got %h expected 9e", rx_data); end
      n_cmp++; if (rv_cnt - rv0 !== 1) begin n_err++; $display("[TB] FAIL midrst_resume_valid: got %0d expected 1", rv_cnt - rv0); end
   endtask

   initial begin
      test_reset();
      test_wrong_addr();
      test_single_write();
      test_read_ignored();
      test_back_to_back();
      test_partial_byte();
      test_reset_mid_transfer();
      n_cmp++; if (oe_bad !== 0) begin n_err++; $display("[TB] FAIL oe_rise_scl_high: got %0d expected 0", oe_bad); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
